// File: rtl/tiny_rv_exec_md_if.sv
// Register-read stage to multiply/divide unit: issue bus, flush and result bus.
interface tiny_rv_exec_md_if #(
  parameter int XLEN = 32
);
  logic            i_flush;
  logic            rr_valid;
  logic [6:0]      rr_opcode;
  logic [2:0]      rr_funct3;
  logic [6:0]      rr_funct7;
  logic [4:0]      rr_rd;
  logic [XLEN-1:0] rr_rs1;
  logic [XLEN-1:0] rr_rs2;
  logic            exec_rr_stall;
  logic            md_busy;
  logic            md_valid;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_rd_val;

  modport master (
    output i_flush, rr_valid, rr_opcode, rr_funct3, rr_funct7, rr_rd, rr_rs1, rr_rs2,
    input  exec_rr_stall, md_busy, md_valid, md_rd, md_rd_val
  );

  modport slave (
    input  i_flush, rr_valid, rr_opcode, rr_funct3, rr_funct7, rr_rd, rr_rs1, rr_rs2,
    output exec_rr_stall, md_busy, md_valid, md_rd, md_rd_val
  );
endinterface

// File: rtl/tiny_rv_exec_md.sv
// Iterative RV M-extension unit: shift-add multiply, restoring divide, one result pulse.
//
// state  | meaning
// IDLE   | waiting for an M-extension instruction
// MUL    | shift-add iterations, MUL_STEP multiplier bits per cycle
// DIV    | restoring divide iterations on magnitudes, one bit per cycle
// DONE   | result registers valid, md_valid pulse, register-read stage released
module tiny_rv_exec_md #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input logic              i_clk,
  input logic              i_reset_n,
  tiny_rv_exec_md_if.slave bus
);
  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("tiny_rv_exec_md: XLEN must be 32 or 64");
    end
    if (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4 && MUL_STEP != 8) begin : g_bad_step
      $error("tiny_rv_exec_md: MUL_STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [2*XLEN-1:0] r_mcand, w_mcand_nxt;
  logic [XLEN-1:0]   r_opb, w_opb_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic [4:0]        r_rd, w_rd_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic [4:0]        r_md_rd;
  logic [XLEN-1:0]   r_md_rd_val;

  logic              w_start;
  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div_ovf;
  logic [XLEN-1:0]   w_a_abs, w_b_abs;
  logic [2*XLEN-1:0] w_mcand_init, w_acc_init;
  logic [2*XLEN-1:0] w_mul_acc, w_div_acc;
  logic [XLEN:0]     w_div_trial;
  logic [XLEN-1:0]   w_quo, w_rem, w_mul_res, w_div_res;
  logic              w_load_res;
  logic [4:0]        w_res_rd;
  logic [XLEN-1:0]   w_res_val;

  assign w_start = bus.rr_valid && (bus.rr_opcode == 7'b0110011) &&
                   (bus.rr_funct7 == 7'b0000001) && (r_state == S_IDLE) && !bus.i_flush;

  // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed
  assign w_a_signed   = (bus.rr_funct3[1:0] == 2'b01) || (bus.rr_funct3[1:0] == 2'b10);
  assign w_b_signed   = (bus.rr_funct3[1:0] == 2'b01);
  assign w_mcand_init = w_a_signed ? {{XLEN{bus.rr_rs1[XLEN-1]}}, bus.rr_rs1}
                                   : {{XLEN{1'b0}}, bus.rr_rs1};
  // the sign bit of an (XLEN+1)-bit multiplier weighs -2^XLEN; pre-load its term
  assign w_acc_init   = (w_b_signed && bus.rr_rs2[XLEN-1])
                        ? {{XLEN{1'b0}} - bus.rr_rs1, {XLEN{1'b0}}} : '0;

  assign w_a_neg   = !bus.rr_funct3[0] && bus.rr_rs1[XLEN-1];
  assign w_b_neg   = !bus.rr_funct3[0] && bus.rr_rs2[XLEN-1];
  assign w_a_abs   = w_a_neg ? {XLEN{1'b0}} - bus.rr_rs1 : bus.rr_rs1;
  assign w_b_abs   = w_b_neg ? {XLEN{1'b0}} - bus.rr_rs2 : bus.rr_rs2;
  assign w_div_ovf = !bus.rr_funct3[0] && (bus.rr_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rr_rs2 == {XLEN{1'b1}});

  always_comb begin
    w_mul_acc = r_acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_opb[j]) w_mul_acc = w_mul_acc + (r_mcand << j);
    end
  end
  assign w_mul_res = (r_funct3 == 3'b000) ? w_mul_acc[XLEN-1:0] : w_mul_acc[2*XLEN-1:XLEN];

  // r_acc holds {partial remainder, dividend/quotient}
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
  assign w_div_acc   = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_quo       = w_div_acc[XLEN-1:0];
  assign w_rem       = w_div_acc[2*XLEN-1:XLEN];
  assign w_div_res   = r_funct3[1] ? (r_neg_r ? -w_rem : w_rem) : (r_neg_q ? -w_quo : w_quo);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_opb_nxt    = r_opb;
    w_funct3_nxt = r_funct3;
    w_rd_nxt     = r_rd;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_load_res   = 1'b0;
    w_res_rd     = r_rd;
    w_res_val    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_funct3_nxt = bus.rr_funct3;
          w_rd_nxt     = bus.rr_rd;
          w_neg_q_nxt  = w_a_neg ^ w_b_neg;
          w_neg_r_nxt  = w_a_neg;
          if (bus.rr_rd == 5'd0) begin
            w_state_nxt = S_DONE;
            w_load_res  = 1'b1;
            w_res_rd    = 5'd0;
            w_res_val   = '0;
          end else if (!bus.rr_funct3[2]) begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = MUL_ITERS;
            w_acc_nxt   = w_acc_init;
            w_mcand_nxt = w_mcand_init;
            w_opb_nxt   = bus.rr_rs2;
          end else if (bus.rr_rs2 == '0) begin
            w_state_nxt = S_DONE;
            w_load_res  = 1'b1;
            w_res_rd    = bus.rr_rd;
            w_res_val   = bus.rr_funct3[1] ? bus.rr_rs1 : {XLEN{1'b1}};
          end else if (w_div_ovf) begin
            w_state_nxt = S_DONE;
            w_load_res  = 1'b1;
            w_res_rd    = bus.rr_rd;
            w_res_val   = bus.rr_funct3[1] ? '0 : bus.rr_rs1;
          end else begin
            w_state_nxt = S_DIV;
            w_cnt_nxt   = DIV_ITERS;
            w_acc_nxt   = {{XLEN{1'b0}}, w_a_abs};
            w_opb_nxt   = w_b_abs;
          end
        end
      end
      S_MUL: begin
        w_cnt_nxt   = r_cnt - CW'(1);
        w_acc_nxt   = w_mul_acc;
        w_mcand_nxt = r_mcand << MUL_STEP;
        w_opb_nxt   = r_opb >> MUL_STEP;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
          w_load_res  = 1'b1;
          w_res_val   = w_mul_res;
        end
      end
      S_DIV: begin
        w_cnt_nxt = r_cnt - CW'(1);
        w_acc_nxt = w_div_acc;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
          w_load_res  = 1'b1;
          w_res_val   = w_div_res;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.i_flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_load_res  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_opb       <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_md_rd     <= '0;
      r_md_rd_val <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_opb    <= w_opb_nxt;
      r_funct3 <= w_funct3_nxt;
      r_rd     <= w_rd_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      if (w_load_res) begin
        r_md_rd     <= w_res_rd;
        r_md_rd_val <= w_res_val;
      end
    end
  end

  assign bus.exec_rr_stall = !bus.i_flush && (w_start || r_state == S_MUL || r_state == S_DIV);
  assign bus.md_busy       = (r_state != S_IDLE);
  assign bus.md_valid      = (r_state == S_DONE) && !bus.i_flush;
  assign bus.md_rd         = r_md_rd;
  assign bus.md_rd_val     = r_md_rd_val;
endmodule

// File: tb/tb_tiny_rv_exec_md.sv
// Directed bench for tiny_rv_exec_md at XLEN=32, MUL_STEP=1.
module tb_tiny_rv_exec_md;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic seen;

  tiny_rv_exec_md_if #(.XLEN(XLEN)) u_if ();

  tiny_rv_exec_md #(.XLEN(XLEN), .MUL_STEP(1)) u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    u_if.rr_valid  = 1'b1;
    u_if.rr_opcode = 7'b0110011;
    u_if.rr_funct7 = 7'b0000001;
    u_if.rr_funct3 = f3;
    u_if.rr_rd     = rd;
    u_if.rr_rs1    = a;
    u_if.rr_rs2    = b;
  endtask

  // scrambled operands while idle so a unit that fails to capture gets a wrong answer
  task automatic idle_bus();
    u_if.rr_valid  = 1'b0;
    u_if.rr_opcode = 7'b0110011;
    u_if.rr_funct7 = 7'b0000001;
    u_if.rr_funct3 = 3'b111;
    u_if.rr_rd     = 5'd31;
    u_if.rr_rs1    = 32'hDEADBEEF;
    u_if.rr_rs2    = 32'h00001234;
  endtask

  // called at a falling edge; that cycle is cycle 0
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_val,
                        input logic [4:0] exp_rd, input int exp_lat);
    int   lat;
    logic got;
    logic stall_ok;
    drive_start(f3, a, b, rd);
    #1 chk({tag, " stall@0"}, u_if.exec_rr_stall, 1'b1);
    @(negedge clk);
    idle_bus();
    #1;
    lat      = 1;
    got      = 1'b0;
    stall_ok = 1'b1;
    while (!got && lat <= 80) begin
      if (u_if.md_valid) got = 1'b1;
      else begin
        if (!u_if.exec_rr_stall) stall_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " stall_hold"}, stall_ok, 1'b1);
    chk({tag, " md_rd"}, u_if.md_rd, exp_rd);
    chk({tag, " md_rd_val"}, u_if.md_rd_val, exp_val);
    // a start offered in DONE must be refused
    drive_start(3'b000, 32'd2, 32'd3, 5'd9);
    #1 chk({tag, " stall@done"}, u_if.exec_rr_stall, 1'b0);
    @(negedge clk);
    chk({tag, " valid_pulse"}, u_if.md_valid, 1'b0);
    chk({tag, " no_start_done"}, u_if.md_busy, 1'b0);
    chk({tag, " val_hold"}, u_if.md_rd_val, exp_val);
    idle_bus();
  endtask

  initial begin
    idle_bus();
    u_if.i_flush = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst md_valid", u_if.md_valid, 1'b0);
    chk("rst md_busy", u_if.md_busy, 1'b0);
    chk("rst md_rd", u_if.md_rd, 5'd0);
    chk("rst md_rd_val", u_if.md_rd_val, 32'd0);
    chk("rst stall", u_if.exec_rr_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",       3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 5'd5,  33);
    run_op("mulhu",     3'b011, 32'd7,          32'hFFFFFFFD, 5'd5,  32'h00000006, 5'd5,  33);
    run_op("mulh",      3'b001, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFFF, 5'd5,  33);
    run_op("mulhsu_a",  3'b010, 32'd7,          32'hFFFFFFFD, 5'd6,  32'h00000006, 5'd6,  33);
    run_op("mulhsu_b",  3'b010, 32'hFFFFFFFD,   32'd7,        5'd6,  32'hFFFFFFFF, 5'd6,  33);
    run_op("div",       3'b100, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFD, 5'd10, 33);
    run_op("rem",       3'b110, 32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFF, 5'd11, 33);
    run_op("divu",      3'b101, 32'd100,        32'd7,        5'd12, 32'd14,       5'd12, 33);
    run_op("remu",      3'b111, 32'd100,        32'd7,        5'd13, 32'd2,        5'd13, 33);
    run_op("divu_by0",  3'b101, 32'd5,          32'd0,        5'd14, 32'hFFFFFFFF, 5'd14, 1);
    run_op("remu_by0",  3'b111, 32'd5,          32'd0,        5'd15, 32'd5,        5'd15, 1);
    run_op("div_ovf",   3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd16, 32'h80000000, 5'd16, 1);
    run_op("rem_ovf",   3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd17, 32'd0,        5'd17, 1);
    run_op("rd_zero",   3'b000, 32'd3,          32'd4,        5'd0,  32'd0,        5'd0,  1);

    // flush in the middle of a divide
    drive_start(3'b100, 32'd1000, 32'd3, 5'd7);
    @(negedge clk);
    idle_bus();
    repeat (9) @(negedge clk);
    u_if.i_flush = 1'b1;
    #1 chk("flush stall_drop", u_if.exec_rr_stall, 1'b0);
    chk("flush busy@10", u_if.md_busy, 1'b1);
    @(negedge clk);
    u_if.i_flush = 1'b0;
    #1 chk("flush busy@11", u_if.md_busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.md_valid) seen = 1'b1;
    end
    chk("flush no_valid", seen, 1'b0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd8, 32'h0000000C, 5'd8, 33);

    // flush while in DONE suppresses the pulse
    drive_start(3'b101, 32'd5, 32'd0, 5'd4);
    @(negedge clk);
    idle_bus();
    u_if.i_flush = 1'b1;
    #1 chk("flush_done valid", u_if.md_valid, 1'b0);
    chk("flush_done busy", u_if.md_busy, 1'b1);
    @(negedge clk);
    u_if.i_flush = 1'b0;
    #1 chk("flush_done busy_after", u_if.md_busy, 1'b0);
    chk("flush_done valid_after", u_if.md_valid, 1'b0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    drive_start(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);
    @(negedge clk);
    idle_bus();
    repeat (14) @(negedge clk);
    chk("arst busy@15", u_if.md_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst md_valid", u_if.md_valid, 1'b0);
    chk("arst md_busy", u_if.md_busy, 1'b0);
    chk("arst md_rd", u_if.md_rd, 5'd0);
    chk("arst md_rd_val", u_if.md_rd_val, 32'd0);
    chk("arst stall", u_if.exec_rr_stall, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.md_valid) seen = 1'b1;
    end
    chk("arst no_valid", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tiny_rv_exec_md.md
TINY_RV_EXEC_MD -- requirements
Module: tiny_rv_exec_md

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL provide parameter MUL_STEP, default 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8.
REQ-003 SHALL fail elaboration for an illegal XLEN or MUL_STEP value.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 rr_valid  in  1  register-read stage holds a valid instruction.
REQ-007 i_flush  in  1  branch-redirect flush; kills any in-flight operation.
REQ-008 rr_opcode  in  7  instruction opcode.
REQ-009 rr_funct3  in  3  selects the operation.
REQ-010 rr_funct7  in  7  M-extension qualifier.
REQ-011 rr_rd  in  5  destination register.
REQ-012 rr_rs1  in  XLEN  operand A (multiplicand or dividend).
REQ-013 rr_rs2  in  XLEN  operand B (multiplier or divisor).
REQ-014 exec_rr_stall  out  1  holds the register-read stage.
REQ-015 md_busy  out  1  state is not IDLE.
REQ-016 md_valid  out  1  result pulse.
REQ-017 md_rd  out  5  destination of the result.
REQ-018 md_rd_val  out  XLEN  result value.

Function
REQ-019 Start condition SHALL be: rr_valid=1, rr_opcode=0110011, rr_funct7=0000001, state=IDLE, i_flush=0.
REQ-020 On start, the block SHALL capture funct3, rd and both operands; it SHALL ignore rr_* inputs until it returns to IDLE.
REQ-021 The FSM SHALL have states IDLE, MUL, DIV and DONE.
- IDLE to MUL on start with funct3[2]=0.
- IDLE to DIV on start with funct3[2]=1.
- MUL or DIV to DONE when the iteration counter expires.
- DONE to IDLE unconditionally.
REQ-022 exec_rr_stall SHALL be combinational: (IDLE and start) or state=MUL or state=DIV; it SHALL be 0 in DONE, so the register-read stage advances on that edge.
REQ-023 The block SHALL never start from DONE.
REQ-024 In DONE, md_valid SHALL be 1 for exactly one cycle, with registered md_rd and md_rd_val; at all other times md_valid SHALL be 0.
REQ-025 md_rd and md_rd_val SHALL hold their last value when md_valid=0.
REQ-026 Multiply SHALL be shift-add, retiring MUL_STEP bits per cycle over a 2*XLEN accumulator.
- Operands SHALL be extended to XLEN+1 bits per funct3.
- md_valid SHALL assert XLEN/MUL_STEP+1 cycles after the start cycle.
REQ-027 Multiply results by funct3:
- 000 MUL: low XLEN bits of the product.
- 001 MULH: high XLEN bits, signed x signed.
- 010 MULHSU: high XLEN bits, signed x unsigned.
- 011 MULHU: high XLEN bits, unsigned x unsigned.
REQ-028 Divide SHALL be restoring, 1 bit per cycle on operand magnitudes, with sign fix-up on entry to DONE; md_valid SHALL assert XLEN+1 cycles after the start cycle.
REQ-029 Divide results by funct3:
- 100 DIV and 101 DIVU: quotient, truncated toward zero.
- 110 REM and 111 REMU: remainder, carrying the sign of the dividend.
REQ-030 Divisor zero SHALL skip iteration and go IDLE to DONE directly.
- Quotient: all ones.
- Remainder: the dividend.
- md_valid 1 cycle after the start cycle.
REQ-031 Signed overflow (dividend = -2^(XLEN-1), divisor = -1) SHALL skip iteration with quotient = dividend and remainder = 0, latency 1 cycle.
REQ-032 rd=0 SHALL skip iteration and complete with md_rd=0 and md_rd_val=0, latency 1 cycle.
REQ-033 i_flush=1 in any state SHALL force IDLE at the next edge and clear the iteration counter.
- md_valid SHALL not assert for the killed operation.
- exec_rr_stall SHALL drop in the same cycle i_flush is asserted.
REQ-034 When i_flush=1 in DONE, md_valid SHALL be forced to 0.
REQ-035 The iteration counter SHALL be log2(XLEN)+1 bits wide and SHALL never wrap; the counter reaching zero terminates the operation.

Reset
REQ-036 i_reset_n=0 SHALL immediately, independent of i_clk:
- force state to IDLE;
- clear the counter, accumulator and operand registers;
- drive md_valid=0, md_rd=0, md_rd_val=0 and md_busy=0.
REQ-037 Reset assertion mid-operation SHALL abandon the operation, with no md_valid afterwards.
REQ-038 The first start after reset release SHALL be accepted at the first clock edge where i_reset_n=1.

Verification (XLEN=32, MUL_STEP=1)
REQ-039 MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> md_valid at cycle 33, md_rd=5, md_rd_val=0xFFFFFFEB; stall high cycles 0-32.
REQ-040 MULHU with same operands -> 0x00000006; MULH -> 0xFFFFFFFF; each with md_valid at cycle 33.
REQ-041 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at cycle 33; REM -> 0xFFFFFFFF.
REQ-042 DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, each at cycle 1.
REQ-043 DIV started, i_flush pulsed at cycle 10 -> no md_valid ever, md_busy=0 at cycle 11; a following MUL 3x4 -> 0x0000000C at its cycle 33.
REQ-044 i_reset_n dropped at cycle 15 of a MUL -> all outputs 0 with no clock edge, no md_valid after release.
